mux_rr_arb: RTL and testbench
=============================

// Module: mux_rr_arb
// PURPOSE
//  Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes. Successor to the
//  4:1 bit mux used in the DLD labs. MANUAL mode forwards the channel on sel; RR mode arbitrates
//  round-robin among requesting channels. Output is one registered stage. Sits between lab data sources
//  and a single downstream consumer (display/UART shim).
// PARAMETERS
//  N_CH   4   number of input channels (>=2)
//  W      8   data width per channel (>=1)
//  CH_W   $clog2(N_CH)   derived localparam; channel index width
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          synchronous, active-high reset
//  mode       in   1          0 = MANUAL, 1 = RR
//  sel        in   CH_W       channel select; used in MANUAL only
//  in_data    in   N_CH*W     channel i at [i*W +: W]
//  in_valid   in   N_CH       per-channel valid
//  in_ready   out  N_CH       per-channel ready; at most one bit high per cycle
//  out_data   out  W          registered data
//  out_ch     out  CH_W       channel index that produced out_data
//  out_valid  out  1          out_data/out_ch hold a valid beat
//  out_ready  in   1          downstream accepts when out_valid & out_ready
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): out_valid=0, out_data=0, out_ch=0, RR pointer=0; in_ready=0 while rst=1.
//  - Output register "free" = !out_valid | out_ready (combinational).
//  - Grant g (combinational): MANUAL: g=sel if in_valid[sel]. RR: first i with in_valid[i], searching from
//    ptr, ptr+1, ..., wrapping mod N_CH. No grant if no candidate is valid.
//  - in_ready[g]=free when a grant exists; all other in_ready bits are 0. Transfer on channel g occurs
//    when in_valid[g] & in_ready[g].
//  - On transfer: next cycle out_data=in_data[g], out_ch=g, out_valid=1. Latency is 1 cycle, with full
//    throughput (1 beat/cycle when out_ready is held 1).
//  - Output pop without new transfer: out_valid->0; out_data/out_ch hold last value.
//  - Stall (out_valid & !out_ready): out_data, out_ch, out_valid are held stable; in_ready is all 0.
//  - RR pointer: on transfer, ptr <= (g==N_CH-1) ? 0 : g+1. Pointer is unchanged in MANUAL mode and
//    when no transfer occurs. Mode changes take effect the same cycle and never corrupt a held output beat.
//  - sel >= N_CH (non-power-of-2 N_CH): treated as no grant; no transfer.
//  - Simultaneous pop and transfer in the same cycle: the new beat is loaded and out_valid stays 1.
//  - Reset mid-stall: the pending beat is discarded and out_valid=0 next cycle.
//  - Upstream must hold in_data stable while in_valid & !in_ready (AXI-style); an assertion checks this
//    on the granted channel.
// STRUCTURE
//  - Package mux_pkg: typedef enum logic {MODE_MANUAL=1'b0, MODE_RR=1'b1} mux_mode_e; and a function
//    wrap_inc(idx, n).
//  - Sub-module rr_arbiter #(N_CH): inputs req[N_CH], ptr, en; outputs gnt_valid, gnt_idx. This is a
//    pure combinational rotate-priority search. The parent owns ptr and the output register.
// TESTING
//  1. Reset: rst=1 for 2 cycles with all in_valid=1.
//     -> out_valid=0, in_ready=0; out_valid is still 0 on the first cycle after rst drops.
//  2. MANUAL: N_CH=4, W=8, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1.
//     -> in_ready=4'b0100; next cycle out_data=A5, out_ch=2, out_valid=1.
//  3. RR fairness: all 4 channels valid continuously, out_ready=1.
//     -> out_ch sequence 0,1,2,3,0,1..., one beat/cycle.
//  4. RR skip/wrap: ptr=3, in_valid=4'b0011.
//     -> grant ch0, then ch1, then ch0 again.
//  5. Backpressure: out_valid=1 with out_data=0x11, out_ready=0 for 3 cycles while ch1 is valid.
//     -> out_data stays 0x11, in_ready=0. When out_ready=1, the ch1 beat appears next cycle.
//  6. Mid-stall reset: stall as in test 5, then rst=1 for 1 cycle.
//     -> out_valid=0 next cycle; RR restarts at ch0.

Source files
------------

// File: rtl/mux_pkg.sv
// Package shared by the registered round-robin multiplexer.
// Contents:
//   mux_mode_e : MANUAL (forward sel) or RR (round-robin arbitration)
//   wrap_inc   : index increment that wraps to 0 at n-1
package mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_RR     = 1'b1
    } mux_mode_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_rr_arb_arbiter.sv
// rr_arbiter: combinational rotate-priority search.
// Ports:
//   req       in  N_CH   request vector
//   ptr       in  CH_W   highest-priority index this cycle
//   en        in  1      enable; no grant when low
//   gnt_valid out 1      some request was found
//   gnt_idx   out CH_W   first requesting index at or after ptr (wrapping)
module rr_arbiter #(
    parameter int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  logic            en,
    output logic            gnt_valid,
    output logic [CH_W-1:0] gnt_idx
);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N_CH) j = j - N_CH;
            if (en && req[j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = CH_W'(j);
            end
        end
    end

endmodule

// File: rtl/mux_rr_arb.sv
// mux_rr_arb: N-channel, W-bit registered multiplexer with valid/ready.
// MANUAL mode forwards the channel on sel, RR mode arbitrates round-robin.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mode                0 = MANUAL, 1 = RR
//   sel                 channel select (MANUAL only)
//   in_data/in_valid    N_CH input channels, channel i at [i*W +: W]
//   in_ready            per-channel ready, at most one bit high
//   out_data/out_ch     registered beat and the channel that produced it
//   out_valid/out_ready output handshake
module mux_rr_arb
    import mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 8,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [CH_W-1:0]   sel,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    output logic [W-1:0]      out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [W-1:0]    data_q, data_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic            vld_q, vld_d;

    logic            rr_mode;
    logic            rr_gnt_valid;
    logic [CH_W-1:0] rr_gnt_idx;
    logic            man_gnt_valid;
    logic            gnt_valid;
    logic [CH_W-1:0] gnt_idx;
    logic [W-1:0]    gnt_data;
    logic            free;
    logic            xfer;

    assign rr_mode = (mux_mode_e'(mode) == MODE_RR);

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .en        (rr_mode),
        .gnt_valid (rr_gnt_valid),
        .gnt_idx   (rr_gnt_idx)
    );

    // Out-of-range sel (non-power-of-2 N_CH) never grants.
    assign man_gnt_valid = !rr_mode && (int'(sel) < N_CH) && in_valid[sel];

    assign gnt_valid = rr_mode ? rr_gnt_valid : man_gnt_valid;
    assign gnt_idx   = rr_mode ? rr_gnt_idx   : sel;
    assign gnt_data  = in_data[gnt_idx*W +: W];

    assign free = !vld_q || out_ready;
    assign xfer = !rst && gnt_valid && free;

    assign in_ready = xfer ? (N_CH'(1) << gnt_idx) : '0;

    always_comb begin
        ptr_d  = ptr_q;
        data_d = data_q;
        ch_d   = ch_q;
        vld_d  = vld_q;
        if (xfer) begin
            data_d = gnt_data;
            ch_d   = gnt_idx;
            vld_d  = 1'b1;
            if (rr_mode) ptr_d = CH_W'(wrap_inc(32'(gnt_idx), N_CH));
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            data_q <= '0;
            ch_q   <= '0;
            vld_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            data_q <= data_d;
            ch_q   <= ch_d;
            vld_q  <= vld_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = vld_q;

    // Upstream stability check: a granted-but-blocked channel must present
    // the same data on the following cycle while it stays valid.
    logic            hold_q;
    logic [CH_W-1:0] hold_ch_q;
    logic [W-1:0]    hold_data_q;

    always_ff @(posedge clk) begin
        hold_q      <= !rst && gnt_valid && !free;
        hold_ch_q   <= gnt_idx;
        hold_data_q <= gnt_data;
    end

    always_ff @(posedge clk) begin
        if (!rst && hold_q && in_valid[hold_ch_q])
            assert (in_data[hold_ch_q*W +: W] == hold_data_q)
                else $error("in_data changed while blocked on ch %0d", hold_ch_q);
    end

endmodule

// File: tb/tb_mux_rr_arb.sv
module tb_mux_rr_arb;

    localparam int N_CH = 4;
    localparam int W    = 8;
    localparam int CH_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              mode;
    logic [CH_W-1:0]   sel;
    logic [N_CH*W-1:0] in_data;
    logic [N_CH-1:0]   in_valid;
    logic [N_CH-1:0]   in_ready;
    logic [W-1:0]      out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_valid;
    logic              out_ready;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mux_rr_arb #(.N_CH(N_CH), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Drive point: 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 1'b1;
        sel       = '0;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        in_data   = {8'hC3, 8'hC2, 8'hC1, 8'hC0};

        // 1. reset with all channels valid
        tick(); #1;
        chk("rst_vld0", 32'(out_valid), 32'd0);
        chk("rst_rdy0", 32'(in_ready), 32'd0);
        tick(); #1;
        chk("rst_vld1", 32'(out_valid), 32'd0);
        chk("rst_rdy1", 32'(in_ready), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ch", 32'(out_ch), 32'd0);
        rst = 1'b0; #1;
        chk("post_rst_vld", 32'(out_valid), 32'd0);
        chk("post_rst_rdy", 32'(in_ready), 32'h1);
        tick(); #1;
        chk("first_beat_vld", 32'(out_valid), 32'd1);
        chk("first_beat_ch", 32'(out_ch), 32'd0);
        chk("first_beat_data", 32'(out_data), 32'hC0);

        // 2. MANUAL sel=2
        do_reset();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100;
        in_data = {8'hC3, 8'hA5, 8'hC1, 8'hC0};
        #1;
        chk("man_rdy", 32'(in_ready), 32'h4);
        tick();
        in_valid = '0; #1;
        chk("man_data", 32'(out_data), 32'hA5);
        chk("man_ch", 32'(out_ch), 32'd2);
        chk("man_vld", 32'(out_valid), 32'd1);
        tick(); #1;
        chk("pop_vld", 32'(out_valid), 32'd0);
        chk("pop_hold_data", 32'(out_data), 32'hA5);
        chk("pop_hold_ch", 32'(out_ch), 32'd2);

        // 3. RR fairness, full throughput
        do_reset();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        in_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        #1;
        chk("rr_rdy0", 32'(in_ready), 32'h1);
        for (int k = 0; k < 6; k++) begin
            tick(); #1;
            chk("rr_vld", 32'(out_valid), 32'd1);
            chk("rr_ch", 32'(out_ch), 32'(k % 4));
            chk("rr_data", 32'(out_data), 32'hC0 + 32'(k % 4));
        end

        // 4. RR skip and wrap from ptr=3
        do_reset();
        mode = 1'b1; in_valid = 4'b0100;
        tick();                          // ch2 taken, ptr -> 3
        in_valid = 4'b0011; #1;
        chk("wrap_rdy0", 32'(in_ready), 32'h1);
        tick(); #1;
        chk("wrap_ch0", 32'(out_ch), 32'd0);
        chk("wrap_rdy1", 32'(in_ready), 32'h2);
        tick(); #1;
        chk("wrap_ch1", 32'(out_ch), 32'd1);
        chk("wrap_rdy2", 32'(in_ready), 32'h1);
        tick(); #1;
        chk("wrap_ch2", 32'(out_ch), 32'd0);

        // 5. backpressure
        do_reset();
        mode = 1'b1; out_ready = 1'b0;
        in_data = {8'hC3, 8'hC2, 8'h5A, 8'h11};
        in_valid = 4'b0001;
        tick();                          // 0x11 loaded, ptr -> 1
        in_valid = 4'b0010; #1;
        chk("bp_vld", 32'(out_valid), 32'd1);
        chk("bp_data", 32'(out_data), 32'h11);
        chk("bp_rdy", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            chk("bp_hold_data", 32'(out_data), 32'h11);
            chk("bp_hold_vld", 32'(out_valid), 32'd1);
            chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1; #1;
        chk("bp_release_rdy", 32'(in_ready), 32'h2);
        tick();
        in_valid = '0; #1;
        chk("bp_after_data", 32'(out_data), 32'h5A);
        chk("bp_after_ch", 32'(out_ch), 32'd1);
        chk("bp_after_vld", 32'(out_valid), 32'd1);

        // 6. reset in the middle of a stall
        do_reset();
        mode = 1'b1; out_ready = 1'b0;
        in_valid = 4'b0001;
        tick();
        in_valid = 4'b0010;
        tick(); #1;
        chk("ms_stall_vld", 32'(out_valid), 32'd1);
        rst = 1'b1; #1;
        chk("ms_rst_rdy", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0; in_valid = 4'hF; #1;
        chk("ms_vld", 32'(out_valid), 32'd0);
        chk("ms_ptr_rdy", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        tick(); #1;
        chk("ms_restart_ch", 32'(out_ch), 32'd0);
        chk("ms_restart_data", 32'(out_data), 32'h11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
